// File: rtl/quadra_pipe_ctrl.sv
// Issue/credit controller for a fixed-latency datapath. Results land in a
// circular buffer; credits keep the buffer from ever overflowing.
module quadra_pipe_ctrl #(
   parameter int WIDTH   = 16,
   parameter int LATENCY = 3,
   parameter int DEPTH   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable_i,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic             issue_o,
   input  logic [WIDTH-1:0] res_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o,
   output logic             busy_o,
   output logic [4:0]       occupancy_o
);

   localparam int              PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [4:0]      DEPTH_C   = 5'(DEPTH);
   localparam logic [4:0]      LAST_WAIT = 5'(LATENCY - 1);
   localparam logic [PW-1:0]   LAST_PTR  = PW'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t             state_reg;
   logic [LATENCY-1:0] vld_reg;
   logic [LATENCY-1:0] vld_next;
   logic [PW-1:0]      wr_ptr_reg;
   logic [PW-1:0]      rd_ptr_reg;
   logic [4:0]         fifo_count_reg;
   logic [4:0]         wait_reg;
   logic [4:0]         inflight;
   logic [4:0]         credits;
   logic               push;
   logic               pop;
   logic [WIDTH-1:0]   mem [DEPTH];

   always_comb begin
      inflight = '0;
      for (int i = 0; i < LATENCY; i++) begin
         inflight = inflight + 5'(vld_reg[i]);
      end
   end

   always_comb begin
      vld_next    = '0;
      vld_next[0] = issue_o;
      for (int i = 1; i < LATENCY; i++) begin
         vld_next[i] = vld_reg[i-1];
      end
   end

   // Credits come from registered counts only, so a pop frees its slot a cycle later.
   assign credits     = DEPTH_C - fifo_count_reg - inflight;
   assign in_ready_o  = (state_reg == RUN) && (credits != 5'd0);
   assign issue_o     = in_valid_i && in_ready_o;
   assign push        = vld_reg[LATENCY-1] && (state_reg != FLUSH);
   assign out_valid_o = (fifo_count_reg != 5'd0);
   assign pop         = out_valid_o && out_ready_i;
   assign out_data_o  = mem[rd_ptr_reg];
   assign occupancy_o = fifo_count_reg + inflight;
   assign busy_o      = (state_reg == FLUSH) || (occupancy_o != 5'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         vld_reg        <= '0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         fifo_count_reg <= '0;
         wait_reg       <= '0;
      end else if (flush_i) begin
         state_reg      <= FLUSH;
         vld_reg        <= '0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         fifo_count_reg <= '0;
         wait_reg       <= '0;
      end else begin
         vld_reg        <= vld_next;
         fifo_count_reg <= fifo_count_reg + 5'(push) - 5'(pop);
         if (push) begin
            wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PW'(1);
         end
         case (state_reg)
            IDLE: if (enable_i) state_reg <= RUN;
            RUN:  if (!enable_i) state_reg <= IDLE;
            FLUSH: begin
               if (wait_reg == LAST_WAIT) begin
                  state_reg <= enable_i ? RUN : IDLE;
                  wait_reg  <= '0;
               end else begin
                  wait_reg <= wait_reg + 5'd1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Storage has no reset; contents are only observed behind a nonzero count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= res_i;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && (fifo_count_reg == DEPTH_C)));

endmodule
